// File: rtl/tl_pkg.sv
// Shared TileLink definitions: D-channel opcodes and the beats-per-message helper.
package tl_pkg;

    typedef enum logic [2:0] {
        D_ACCESS_ACK      = 3'd0,
        D_ACCESS_ACK_DATA = 3'd1,
        D_GRANT           = 3'd4,
        D_GRANT_DATA      = 3'd5,
        D_RELEASE_ACK     = 3'd6
    } tl_d_opcode_e;

    // Number of bus beats for a data-carrying message of 2**size bytes.
    function automatic int unsigned tl_beats(input int unsigned size, input int unsigned beat_log2);
        if (size <= beat_log2) begin
            return 32'd1;
        end else begin
            return 32'd1 << (size - beat_log2);
        end
    endfunction

endpackage

// File: rtl/tl_sink_alloc_table.sv
// Sink remap table: per-entry valid bit and wide device sink, lowest-free
// priority encoder and full flag.
module tl_sink_alloc_table #(
    parameter  int HostSinkWidth   = 1,
    parameter  int DeviceSinkWidth = 4,
    localparam int N               = 2**HostSinkWidth
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           i_alloc,
    input  logic [DeviceSinkWidth-1:0]     i_alloc_sink,
    input  logic                           i_free,
    input  logic [HostSinkWidth-1:0]       i_free_idx,
    output logic [HostSinkWidth-1:0]       o_cand_idx,
    output logic                           o_full,
    output logic [N-1:0]                   o_valid,
    output logic [N-1:0][DeviceSinkWidth-1:0] o_sinks
);

    logic [N-1:0]                      r_valid;
    logic [N-1:0][DeviceSinkWidth-1:0] r_sinks;

    // Lowest free index; scanning downwards lets the lowest match win.
    always_comb begin
        o_cand_idx = {HostSinkWidth{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                o_cand_idx = HostSinkWidth'(i);
            end else begin
                o_cand_idx = o_cand_idx;
            end
        end
        o_full = &r_valid;
    end

    // Allocation only ever targets a free entry, so it cannot collide with a free.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= {N{1'b0}};
            r_sinks <= {(N*DeviceSinkWidth){1'b0}};
        end else begin
            if (i_alloc) begin
                r_valid[o_cand_idx] <= 1'b1;
                r_sinks[o_cand_idx] <= i_alloc_sink;
            end
            if (i_free) begin
                r_valid[i_free_idx] <= 1'b0;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_sinks = r_sinks;

endmodule

// File: rtl/tl_sink_downsizer_sva.sv
// Protocol checker for tl_sink_downsizer; instantiated only when
// TL_SINK_DOWNSIZER_ASSERT_EN is defined.
module tl_sink_downsizer_sva #(
    parameter  int HostSinkWidth   = 1,
    parameter  int DeviceSinkWidth = 4,
    parameter  int BeatW           = 7,
    parameter  int BundleW         = 8,
    localparam int N               = 2**HostSinkWidth
) (
    input logic                              clk_i,
    input logic                              rst_i,
    input logic                              i_d_valid,
    input logic                              i_d_ready,
    input logic [BundleW-1:0]                i_d_bundle,
    input logic                              i_dev_d_valid,
    input logic [BeatW-1:0]                  i_beat_cnt,
    input logic [BeatW-1:0]                  i_beats,
    input logic                              i_e_fire,
    input logic [HostSinkWidth-1:0]          i_e_sink,
    input logic [N-1:0]                      i_valid,
    input logic [N-1:0][DeviceSinkWidth-1:0] i_sinks
);

    logic w_dup;

    // Any two live entries mapping the same device sink.
    always_comb begin
        w_dup = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
                if (i_valid[i] && i_valid[j] && (i_sinks[i] == i_sinks[j])) begin
                    w_dup = 1'b1;
                end else begin
                    w_dup = w_dup;
                end
            end
        end
    end

    a_e_hits_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        i_e_fire |-> i_valid[i_e_sink]);
    a_unique_sinks: assert property (@(posedge clk_i) disable iff (rst_i) !w_dup);
    a_beat_count: assert property (@(posedge clk_i) disable iff (rst_i)
        i_dev_d_valid |-> (i_beat_cnt < i_beats));
    a_d_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (i_d_valid && !i_d_ready) |=> (i_d_valid && $stable(i_d_bundle)));

endmodule

// File: rtl/tl_sink_downsizer.sv
// TileLink D-channel sink narrowing adapter with GrantAck sink restoration.
// Define TL_SINK_DOWNSIZER_ASSERT_EN to bind in the protocol checker.
module tl_sink_downsizer import tl_pkg::*; #(
    parameter  int DataWidth       = 64,
    parameter  int AddrWidth       = 56,
    parameter  int SourceWidth     = 1,
    parameter  int HostSinkWidth   = 1,
    parameter  int DeviceSinkWidth = 4,
    parameter  int MaxSize         = 6,
    localparam int SizeWidth       = $clog2(MaxSize + 1),
    localparam int MaskWidth       = DataWidth / 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    // A channel, host to device
    input  logic                       host_a_valid,
    output logic                       host_a_ready,
    input  logic [2:0]                 host_a_opcode,
    input  logic [2:0]                 host_a_param,
    input  logic [SizeWidth-1:0]       host_a_size,
    input  logic [SourceWidth-1:0]     host_a_source,
    input  logic [AddrWidth-1:0]       host_a_address,
    input  logic [MaskWidth-1:0]       host_a_mask,
    input  logic [DataWidth-1:0]       host_a_data,
    input  logic                       host_a_corrupt,
    output logic                       device_a_valid,
    input  logic                       device_a_ready,
    output logic [2:0]                 device_a_opcode,
    output logic [2:0]                 device_a_param,
    output logic [SizeWidth-1:0]       device_a_size,
    output logic [SourceWidth-1:0]     device_a_source,
    output logic [AddrWidth-1:0]       device_a_address,
    output logic [MaskWidth-1:0]       device_a_mask,
    output logic [DataWidth-1:0]       device_a_data,
    output logic                       device_a_corrupt,
    // B channel, device to host
    input  logic                       device_b_valid,
    output logic                       device_b_ready,
    input  logic [2:0]                 device_b_opcode,
    input  logic [1:0]                 device_b_param,
    input  logic [SizeWidth-1:0]       device_b_size,
    input  logic [SourceWidth-1:0]     device_b_source,
    input  logic [AddrWidth-1:0]       device_b_address,
    input  logic [MaskWidth-1:0]       device_b_mask,
    input  logic [DataWidth-1:0]       device_b_data,
    input  logic                       device_b_corrupt,
    output logic                       host_b_valid,
    input  logic                       host_b_ready,
    output logic [2:0]                 host_b_opcode,
    output logic [1:0]                 host_b_param,
    output logic [SizeWidth-1:0]       host_b_size,
    output logic [SourceWidth-1:0]     host_b_source,
    output logic [AddrWidth-1:0]       host_b_address,
    output logic [MaskWidth-1:0]       host_b_mask,
    output logic [DataWidth-1:0]       host_b_data,
    output logic                       host_b_corrupt,
    // C channel, host to device
    input  logic                       host_c_valid,
    output logic                       host_c_ready,
    input  logic [2:0]                 host_c_opcode,
    input  logic [2:0]                 host_c_param,
    input  logic [SizeWidth-1:0]       host_c_size,
    input  logic [SourceWidth-1:0]     host_c_source,
    input  logic [AddrWidth-1:0]       host_c_address,
    input  logic [DataWidth-1:0]       host_c_data,
    input  logic                       host_c_corrupt,
    output logic                       device_c_valid,
    input  logic                       device_c_ready,
    output logic [2:0]                 device_c_opcode,
    output logic [2:0]                 device_c_param,
    output logic [SizeWidth-1:0]       device_c_size,
    output logic [SourceWidth-1:0]     device_c_source,
    output logic [AddrWidth-1:0]       device_c_address,
    output logic [DataWidth-1:0]       device_c_data,
    output logic                       device_c_corrupt,
    // D channel, device to host
    input  logic                       device_d_valid,
    output logic                       device_d_ready,
    input  logic [2:0]                 device_d_opcode,
    input  logic [1:0]                 device_d_param,
    input  logic [SizeWidth-1:0]       device_d_size,
    input  logic [SourceWidth-1:0]     device_d_source,
    input  logic [DeviceSinkWidth-1:0] device_d_sink,
    input  logic                       device_d_denied,
    input  logic                       device_d_corrupt,
    input  logic [DataWidth-1:0]       device_d_data,
    output logic                       host_d_valid,
    input  logic                       host_d_ready,
    output logic [2:0]                 host_d_opcode,
    output logic [1:0]                 host_d_param,
    output logic [SizeWidth-1:0]       host_d_size,
    output logic [SourceWidth-1:0]     host_d_source,
    output logic [HostSinkWidth-1:0]   host_d_sink,
    output logic                       host_d_denied,
    output logic                       host_d_corrupt,
    output logic [DataWidth-1:0]       host_d_data,
    // E channel, host to device
    input  logic                       host_e_valid,
    output logic                       host_e_ready,
    input  logic [HostSinkWidth-1:0]   host_e_sink,
    output logic                       device_e_valid,
    input  logic                       device_e_ready,
    output logic [DeviceSinkWidth-1:0] device_e_sink
);

    localparam int          N        = 2**HostSinkWidth;
    localparam int          BeatW    = MaxSize + 1;
    localparam int unsigned BeatLog2 = $clog2(DataWidth / 8);

    logic [MaxSize-1:0]       r_beat_cnt;
    logic                     r_lock;
    logic [HostSinkWidth-1:0] r_lock_idx;

    logic                              w_tracked;
    logic                              w_has_data;
    logic [BeatW-1:0]                  w_beats;
    logic                              w_last;
    logic                              w_stall;
    logic                              w_d_fire;
    logic                              w_e_fire;
    logic                              w_alloc;
    logic                              w_free;
    logic                              w_full;
    logic [HostSinkWidth-1:0]          w_cand;
    logic [N-1:0]                      w_valid;
    logic [N-1:0][DeviceSinkWidth-1:0] w_sinks;

    assign host_a_ready     = device_a_ready;
    assign device_a_valid   = host_a_valid;
    assign device_a_opcode  = host_a_opcode;
    assign device_a_param   = host_a_param;
    assign device_a_size    = host_a_size;
    assign device_a_source  = host_a_source;
    assign device_a_address = host_a_address;
    assign device_a_mask    = host_a_mask;
    assign device_a_data    = host_a_data;
    assign device_a_corrupt = host_a_corrupt;

    assign device_b_ready   = host_b_ready;
    assign host_b_valid     = device_b_valid;
    assign host_b_opcode    = device_b_opcode;
    assign host_b_param     = device_b_param;
    assign host_b_size      = device_b_size;
    assign host_b_source    = device_b_source;
    assign host_b_address   = device_b_address;
    assign host_b_mask      = device_b_mask;
    assign host_b_data      = device_b_data;
    assign host_b_corrupt   = device_b_corrupt;

    assign host_c_ready     = device_c_ready;
    assign device_c_valid   = host_c_valid;
    assign device_c_opcode  = host_c_opcode;
    assign device_c_param   = host_c_param;
    assign device_c_size    = host_c_size;
    assign device_c_source  = host_c_source;
    assign device_c_address = host_c_address;
    assign device_c_data    = host_c_data;
    assign device_c_corrupt = host_c_corrupt;

    assign host_d_opcode    = device_d_opcode;
    assign host_d_param     = device_d_param;
    assign host_d_size      = device_d_size;
    assign host_d_source    = device_d_source;
    assign host_d_denied    = device_d_denied;
    assign host_d_corrupt   = device_d_corrupt;
    assign host_d_data      = device_d_data;

    // D-channel beat accounting, table stall and sink remapping.
    always_comb begin
        w_tracked  = (device_d_opcode == D_GRANT) || (device_d_opcode == D_GRANT_DATA);
        w_has_data = (device_d_opcode == D_ACCESS_ACK_DATA) || (device_d_opcode == D_GRANT_DATA);
        if (w_has_data) begin
            w_beats = BeatW'(tl_beats(32'(device_d_size), BeatLog2));
        end else begin
            w_beats = BeatW'(1);
        end
        w_last   = ({1'b0, r_beat_cnt} == (w_beats - BeatW'(1)));
        w_stall  = w_tracked && !r_lock && w_full;
        host_d_valid   = device_d_valid && !w_stall;
        device_d_ready = host_d_ready && !w_stall;
        w_d_fire = device_d_valid && device_d_ready;
        w_alloc  = w_d_fire && w_tracked && !r_lock;
        if (!w_tracked) begin
            host_d_sink = {HostSinkWidth{1'b0}};
        end else if (r_lock) begin
            host_d_sink = r_lock_idx;
        end else begin
            host_d_sink = w_cand;
        end
    end

    // E channel restores the wide sink; acks to dead entries leave the table alone.
    always_comb begin
        device_e_valid = host_e_valid;
        host_e_ready   = device_e_ready;
        device_e_sink  = w_sinks[host_e_sink];
        w_e_fire       = host_e_valid && device_e_ready;
        w_free         = w_e_fire && w_valid[host_e_sink];
    end

    // Beat counter and burst lock; a multi-beat tracked first beat pins its index.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_beat_cnt <= {MaxSize{1'b0}};
            r_lock     <= 1'b0;
            r_lock_idx <= {HostSinkWidth{1'b0}};
        end else if (w_d_fire) begin
            if (w_last) begin
                r_beat_cnt <= {MaxSize{1'b0}};
                r_lock     <= 1'b0;
            end else begin
                r_beat_cnt <= r_beat_cnt + MaxSize'(1);
                if (w_alloc) begin
                    r_lock     <= 1'b1;
                    r_lock_idx <= w_cand;
                end
            end
        end
    end

    tl_sink_alloc_table #(
        .HostSinkWidth   (HostSinkWidth),
        .DeviceSinkWidth (DeviceSinkWidth)
    ) u_table (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_alloc      (w_alloc),
        .i_alloc_sink (device_d_sink),
        .i_free       (w_free),
        .i_free_idx   (host_e_sink),
        .o_cand_idx   (w_cand),
        .o_full       (w_full),
        .o_valid      (w_valid),
        .o_sinks      (w_sinks)
    );

`ifdef TL_SINK_DOWNSIZER_ASSERT_EN
    localparam int BundleW = 3 + 2 + SizeWidth + SourceWidth + HostSinkWidth + 2 + DataWidth;

    tl_sink_downsizer_sva #(
        .HostSinkWidth   (HostSinkWidth),
        .DeviceSinkWidth (DeviceSinkWidth),
        .BeatW           (BeatW),
        .BundleW         (BundleW)
    ) u_sva (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .i_d_valid     (host_d_valid),
        .i_d_ready     (host_d_ready),
        .i_d_bundle    ({host_d_opcode, host_d_param, host_d_size, host_d_source,
                         host_d_sink, host_d_denied, host_d_corrupt, host_d_data}),
        .i_dev_d_valid (device_d_valid),
        .i_beat_cnt    ({1'b0, r_beat_cnt}),
        .i_beats       (w_beats),
        .i_e_fire      (w_e_fire),
        .i_e_sink      (host_e_sink),
        .i_valid       (w_valid),
        .i_sinks       (w_sinks)
    );
`else
`endif

endmodule

// File: tb/tb_tl_sink_downsizer.sv
// Scoreboard bench for tl_sink_downsizer: directed D/E traffic with queued expectations.
module tb_tl_sink_downsizer;
    import tl_pkg::*;

    localparam int DW = 64, AW = 56, SW = 1, HSW = 1, DSW = 4, SZW = 3, MW = 8;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;
    logic rst_i;

    logic host_a_valid, host_a_ready, host_a_corrupt, device_a_valid, device_a_ready, device_a_corrupt;
    logic [2:0] host_a_opcode, host_a_param, device_a_opcode, device_a_param;
    logic [SZW-1:0] host_a_size, device_a_size;
    logic [SW-1:0] host_a_source, device_a_source;
    logic [AW-1:0] host_a_address, device_a_address;
    logic [MW-1:0] host_a_mask, device_a_mask;
    logic [DW-1:0] host_a_data, device_a_data;

    logic device_b_valid, device_b_ready, device_b_corrupt, host_b_valid, host_b_ready, host_b_corrupt;
    logic [2:0] device_b_opcode, host_b_opcode;
    logic [1:0] device_b_param, host_b_param;
    logic [SZW-1:0] device_b_size, host_b_size;
    logic [SW-1:0] device_b_source, host_b_source;
    logic [AW-1:0] device_b_address, host_b_address;
    logic [MW-1:0] device_b_mask, host_b_mask;
    logic [DW-1:0] device_b_data, host_b_data;

    logic host_c_valid, host_c_ready, host_c_corrupt, device_c_valid, device_c_ready, device_c_corrupt;
    logic [2:0] host_c_opcode, host_c_param, device_c_opcode, device_c_param;
    logic [SZW-1:0] host_c_size, device_c_size;
    logic [SW-1:0] host_c_source, device_c_source;
    logic [AW-1:0] host_c_address, device_c_address;
    logic [DW-1:0] host_c_data, device_c_data;

    logic device_d_valid, device_d_ready, device_d_denied, device_d_corrupt;
    logic [2:0] device_d_opcode, host_d_opcode;
    logic [1:0] device_d_param, host_d_param;
    logic [SZW-1:0] device_d_size, host_d_size;
    logic [SW-1:0] device_d_source, host_d_source;
    logic [DSW-1:0] device_d_sink;
    logic [DW-1:0] device_d_data, host_d_data;
    logic host_d_valid, host_d_ready, host_d_denied, host_d_corrupt;
    logic [HSW-1:0] host_d_sink;

    logic host_e_valid, host_e_ready, device_e_valid, device_e_ready;
    logic [HSW-1:0] host_e_sink;
    logic [DSW-1:0] device_e_sink;

    tl_sink_downsizer dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .host_a_valid(host_a_valid), .host_a_ready(host_a_ready), .host_a_opcode(host_a_opcode),
        .host_a_param(host_a_param), .host_a_size(host_a_size), .host_a_source(host_a_source),
        .host_a_address(host_a_address), .host_a_mask(host_a_mask), .host_a_data(host_a_data),
        .host_a_corrupt(host_a_corrupt),
        .device_a_valid(device_a_valid), .device_a_ready(device_a_ready), .device_a_opcode(device_a_opcode),
        .device_a_param(device_a_param), .device_a_size(device_a_size), .device_a_source(device_a_source),
        .device_a_address(device_a_address), .device_a_mask(device_a_mask), .device_a_data(device_a_data),
        .device_a_corrupt(device_a_corrupt),
        .device_b_valid(device_b_valid), .device_b_ready(device_b_ready), .device_b_opcode(device_b_opcode),
        .device_b_param(device_b_param), .device_b_size(device_b_size), .device_b_source(device_b_source),
        .device_b_address(device_b_address), .device_b_mask(device_b_mask), .device_b_data(device_b_data),
        .device_b_corrupt(device_b_corrupt),
        .host_b_valid(host_b_valid), .host_b_ready(host_b_ready), .host_b_opcode(host_b_opcode),
        .host_b_param(host_b_param), .host_b_size(host_b_size), .host_b_source(host_b_source),
        .host_b_address(host_b_address), .host_b_mask(host_b_mask), .host_b_data(host_b_data),
        .host_b_corrupt(host_b_corrupt),
        .host_c_valid(host_c_valid), .host_c_ready(host_c_ready), .host_c_opcode(host_c_opcode),
        .host_c_param(host_c_param), .host_c_size(host_c_size), .host_c_source(host_c_source),
        .host_c_address(host_c_address), .host_c_data(host_c_data), .host_c_corrupt(host_c_corrupt),
        .device_c_valid(device_c_valid), .device_c_ready(device_c_ready), .device_c_opcode(device_c_opcode),
        .device_c_param(device_c_param), .device_c_size(device_c_size), .device_c_source(device_c_source),
        .device_c_address(device_c_address), .device_c_data(device_c_data), .device_c_corrupt(device_c_corrupt),
        .device_d_valid(device_d_valid), .device_d_ready(device_d_ready), .device_d_opcode(device_d_opcode),
        .device_d_param(device_d_param), .device_d_size(device_d_size), .device_d_source(device_d_source),
        .device_d_sink(device_d_sink), .device_d_denied(device_d_denied), .device_d_corrupt(device_d_corrupt),
        .device_d_data(device_d_data),
        .host_d_valid(host_d_valid), .host_d_ready(host_d_ready), .host_d_opcode(host_d_opcode),
        .host_d_param(host_d_param), .host_d_size(host_d_size), .host_d_source(host_d_source),
        .host_d_sink(host_d_sink), .host_d_denied(host_d_denied), .host_d_corrupt(host_d_corrupt),
        .host_d_data(host_d_data),
        .host_e_valid(host_e_valid), .host_e_ready(host_e_ready), .host_e_sink(host_e_sink),
        .device_e_valid(device_e_valid), .device_e_ready(device_e_ready), .device_e_sink(device_e_sink)
    );

    typedef struct packed {
        logic [HSW-1:0] sink;
        logic [2:0]     op;
        logic [DW-1:0]  data;
    } d_exp_t;

    d_exp_t         exp_d[$];
    logic [DSW-1:0] exp_e[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Host D monitor: every accepted beat must match the head of the queue.
    always @(negedge clk_i) begin
        if (host_d_valid && host_d_ready) begin
            if (exp_d.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL d_unexpected_beat: got sink %0h data %0h, required no beat", host_d_sink, host_d_data);
            end else begin
                d_exp_t e;
                e = exp_d.pop_front();
                chk("d_sink", 64'(host_d_sink), 64'(e.sink));
                chk("d_opcode", 64'(host_d_opcode), 64'(e.op));
                chk("d_data", host_d_data, e.data);
            end
        end
    end

    // Device E monitor: restored wide sink on every accepted GrantAck.
    always @(negedge clk_i) begin
        if (device_e_valid && device_e_ready) begin
            if (exp_e.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL e_unexpected_ack: got sink %0h, required no ack", device_e_sink);
            end else begin
                logic [DSW-1:0] s;
                s = exp_e.pop_front();
                chk("e_sink", 64'(device_e_sink), 64'(s));
            end
        end
    end

    task automatic send_d(input logic [2:0] op, input logic [SZW-1:0] sz, input logic [DSW-1:0] snk,
                          input logic [HSW-1:0] hs, input int nbeats, input bit tog);
        for (int b = 0; b < nbeats; b++) begin
            bit fired;
            int guard;
            d_exp_t e;
            fired  = 1'b0;
            guard  = 0;
            e.sink = hs;
            e.op   = op;
            e.data = {32'hC0DE0000 | 32'(snk), 32'(b)};
            exp_d.push_back(e);
            device_d_valid  = 1'b1;
            device_d_opcode = op;
            device_d_size   = sz;
            device_d_sink   = snk;
            device_d_data   = e.data;
            do begin
                @(negedge clk_i);
                fired = device_d_valid && device_d_ready;
                @(posedge clk_i);
                #1;
                if (tog) host_d_ready = ~host_d_ready;
                guard++;
            end while (!fired && guard < 200);
            if (!fired) begin
                n_checks++;
                n_fail++;
                $display("FAIL d_timeout: beat %0d of sink %0h not accepted, required acceptance", b, snk);
            end
        end
        device_d_valid = 1'b0;
        host_d_ready   = 1'b1;
    endtask

    task automatic send_e(input logic [HSW-1:0] idx, input logic [DSW-1:0] exp);
        bit fired;
        int guard;
        fired = 1'b0;
        guard = 0;
        exp_e.push_back(exp);
        @(posedge clk_i);
        #1;
        host_e_valid = 1'b1;
        host_e_sink  = idx;
        do begin
            @(negedge clk_i);
            fired = host_e_valid && host_e_ready;
            @(posedge clk_i);
            #1;
            guard++;
        end while (!fired && guard < 100);
        host_e_valid = 1'b0;
        if (!fired) begin
            n_checks++;
            n_fail++;
            $display("FAIL e_timeout: ack idx %0h not accepted, required acceptance", idx);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        {host_a_valid, host_a_opcode, host_a_param, host_a_size, host_a_source, host_a_address,
         host_a_mask, host_a_data, host_a_corrupt} = '0;
        {device_b_valid, device_b_opcode, device_b_param, device_b_size, device_b_source,
         device_b_address, device_b_mask, device_b_data, device_b_corrupt} = '0;
        {host_c_valid, host_c_opcode, host_c_param, host_c_size, host_c_source, host_c_address,
         host_c_data, host_c_corrupt} = '0;
        device_a_ready = 1'b1; host_b_ready = 1'b1; device_c_ready = 1'b1;
        {device_d_valid, device_d_opcode, device_d_param, device_d_size, device_d_source,
         device_d_sink, device_d_denied, device_d_corrupt, device_d_data} = '0;
        host_d_ready   = 1'b1;
        host_e_valid   = 1'b0;
        host_e_sink    = 1'b0;
        device_e_ready = 1'b1;
        rst_i          = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;

        @(negedge clk_i);
        chk("reset_host_d_valid", 64'(host_d_valid), 64'd0);
        chk("reset_device_e_valid", 64'(device_e_valid), 64'd0);
        chk("reset_device_d_ready", 64'(device_d_ready), 64'd1);
        host_a_valid = 1'b1;
        #1 chk("a_passthrough_valid", 64'(device_a_valid), 64'd1);
        host_a_valid = 1'b0;
        @(posedge clk_i);
        #1;

        // Single Grant round trip, then a stale ack to the freed entry.
        send_d(D_GRANT, 3'd0, 4'd9, 1'b0, 1, 1'b0);
        send_e(1'b0, 4'd9);
        send_d(D_GRANT, 3'd0, 4'd7, 1'b0, 1, 1'b0);
        send_e(1'b0, 4'd7);
        send_e(1'b0, 4'd7);

        // Fill the table; third Grant stalls until entry 1 is acknowledged.
        send_d(D_GRANT, 3'd0, 4'd3, 1'b0, 1, 1'b0);
        send_d(D_GRANT, 3'd0, 4'd12, 1'b1, 1, 1'b0);
        fork
            send_d(D_GRANT, 3'd0, 4'd5, 1'b1, 1, 1'b0);
            begin
                @(negedge clk_i);
                chk("full_stall_d_ready", 64'(device_d_ready), 64'd0);
                @(negedge clk_i);
                chk("full_stall_host_valid", 64'(host_d_valid), 64'd0);
                send_e(1'b1, 4'd12);
                @(negedge clk_i);
                chk("after_free_d_ready", 64'(device_d_ready), 64'd1);
            end
        join

        // Stalled Grant with a GrantAck for entry 0 in flight.
        fork
            send_d(D_GRANT, 3'd0, 4'd10, 1'b0, 1, 1'b0);
            send_e(1'b0, 4'd3);
        join
        send_e(1'b1, 4'd5);
        send_e(1'b0, 4'd10);

        // 8-beat GrantData with a toggling host ready; one allocation only.
        send_d(D_GRANT_DATA, 3'd6, 4'd6, 1'b0, 8, 1'b1);
        send_d(D_GRANT, 3'd0, 4'd2, 1'b1, 1, 1'b0);
        send_e(1'b1, 4'd2);
        send_e(1'b0, 4'd6);

        // AccessAckData passes with sink 0 and leaves the table untouched.
        send_d(D_GRANT, 3'd0, 4'd11, 1'b0, 1, 1'b0);
        send_d(D_ACCESS_ACK_DATA, 3'd4, 4'd15, 1'b0, 2, 1'b0);
        send_d(D_GRANT, 3'd0, 4'd13, 1'b1, 1, 1'b0);
        send_e(1'b0, 4'd11);
        send_e(1'b1, 4'd13);

        // Reset in the middle of a locked GrantData burst.
        send_d(D_GRANT, 3'd0, 4'd4, 1'b0, 1, 1'b0);
        send_d(D_GRANT_DATA, 3'd6, 4'd6, 1'b1, 3, 1'b0);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("midburst_reset_host_valid", 64'(host_d_valid), 64'd0);
        @(posedge clk_i);
        #1;
        send_d(D_GRANT, 3'd0, 4'd8, 1'b0, 1, 1'b0);
        send_d(D_GRANT, 3'd0, 4'd1, 1'b1, 1, 1'b0);
        send_e(1'b0, 4'd8);
        send_e(1'b1, 4'd1);

        repeat (3) @(posedge clk_i);
        chk("d_queue_drained", 64'(exp_d.size()), 64'd0);
        chk("e_queue_drained", 64'(exp_e.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_sink_downsizer.md
Name: tl_sink_downsizer

Overview:
- TileLink adapter that narrows the D-channel sink ID space.
- Compresses wide device-side sink IDs (DeviceSinkWidth) into a narrow host-side sink space (HostSinkWidth).
- Holds a remap table of 2**HostSinkWidth entries. An entry is allocated on each Grant/GrantData and freed when the matching E-channel GrantAck passes.
- Sits between a host with a narrow sink field and a device (e.g. a coherence manager) issuing wide sinks.

Parameters:
- DataWidth, 64, data bus width in bits; power of two, >= 8.
- AddrWidth, 56, address width.
- SourceWidth, 1, source ID width; both sides identical.
- HostSinkWidth, 1, narrow sink width on the host port; must be < DeviceSinkWidth.
- DeviceSinkWidth, 4, wide sink width on the device port.
- MaxSize, 6, log2 of the maximum transfer in bytes.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, reset: synchronous, active-high.
- host_{a,b,c}_*, device_{a,b,c}_*: standard TL A/B/C bundles at the module widths, wired straight through.
- device_d_valid / device_d_ready, input / output, 1 / 1, device D handshake.
- device_d_opcode / device_d_param / device_d_size / device_d_source, input, 3/2/SizeWidth/SourceWidth, device D fields.
- device_d_sink / device_d_denied / device_d_corrupt / device_d_data, input, DeviceSinkWidth/1/1/DataWidth, device D fields.
- host_d_valid / host_d_ready, output / input, 1 / 1, host D handshake.
- host_d_sink, output, HostSinkWidth, remapped sink.
- host_d_{opcode,param,size,source,denied,corrupt,data}, output, widths as the device D fields, copies of the device fields.
- host_e_valid / host_e_ready, input / output, 1 / 1, host E handshake.
- host_e_sink, input, HostSinkWidth, narrow sink being acknowledged.
- device_e_valid / device_e_ready, output / input, 1 / 1, device E handshake.
- device_e_sink, output, DeviceSinkWidth, restored wide sink.

Behaviour:
- Combinational datapath, zero added latency. All state updates on the rising edge of clk_i.
- Reset (rst_i=1 at a clock edge):
  - all valid bits cleared, beat counter = 0, burst-lock cleared;
  - host_d_valid and device_e_valid are pure functions of their inputs, so they are 0 whenever their source valids are 0.
- State:
  - valid[N], wide_sink[N] (DeviceSinkWidth each), N = 2**HostSinkWidth;
  - beat counter (MaxSize bits);
  - locked index plus lock flag.
- Tracked D messages: opcode Grant (4) or GrantData (5).
  - Other D opcodes pass through with host_d_sink = 0 and no allocation.
- Beats per message:
  - AccessAckData and GrantData: max(1, 2**size / (DataWidth/8));
  - all other opcodes: 1.
  - The counter increments on each D handshake and returns to 0 after the last beat.
- First beat of a tracked message:
  - candidate = lowest index with valid=0;
  - if none is free: host_d_valid = 0 and device_d_ready = 0 (stall, no data lost);
  - otherwise host_d_valid = device_d_valid, device_d_ready = host_d_ready, host_d_sink = candidate;
  - on handshake: valid[candidate] <= 1, wide_sink[candidate] <= device_d_sink, lock flag set if beats > 1.
- Subsequent beats of a tracked message: host_d_sink = locked index, no new allocation, never stalled by the table.
- Lock flag clears on the last-beat handshake.
- E channel:
  - device_e_valid = host_e_valid, host_e_ready = device_e_ready;
  - device_e_sink = wide_sink[host_e_sink];
  - on handshake: valid[host_e_sink] <= 0.
- Simultaneous allocate and free in one cycle:
  - allocation uses the pre-edge valid vector, so it never selects the entry being freed that cycle;
  - both updates commit; the freed entry becomes available the following cycle.
- Table full with a GrantAck arriving: the free is visible next cycle and the stalled Grant proceeds one cycle later.
- GrantAck to an invalid entry: a protocol error. device_e_sink still forwards the stale table value and the table is unchanged.
- Reset mid-burst: counter and lock are dropped and the table is cleared; the next D beat is treated as a first beat.

Optional Feature:
- TL_SINK_DOWNSIZER_ASSERT_EN defined: SVA concurrent assertions, disabled during rst_i, check that:
  - E handshakes only hit valid entries;
  - device sinks are unique among valid entries;
  - the D beat count is consistent with size;
  - host_d signals stay stable while valid and not ready.
- Undefined: no assertions and identical RTL behaviour.

Decomposition:
- Shared package tl_pkg:
  - D opcode enum (AccessAck, AccessAckData, Grant, GrantData, ReleaseAck);
  - helper function for beats from size and DataWidth.
- Natural sub-module: tl_sink_alloc_table. It holds the valid/wide_sink arrays, the lowest-free priority encoder, the full flag and the alloc/free ports.

Test Plan:
- Grant, device sink 9, host_d_ready=1 -> host_d_sink=0, entry0 valid; GrantAck sink 0 -> device_e_sink=9, entry0 freed.
- Two Grants (sinks 3, 12) with no acks, then a third Grant (sink 5) -> third is stalled with device_d_ready=0; GrantAck sink 1 -> third passes one cycle later as host sink 1.
- GrantData size 6, DataWidth 64 -> 8 beats, all with host_d_sink=0, a single allocation; host_d_ready toggled every other cycle -> no beat dropped or duplicated.
- Table full, GrantAck sink 0 in the same cycle as a stalled Grant -> Grant accepted next cycle with host_d_sink=0.
- AccessAckData size 4 -> 2 beats, host_d_sink=0, table untouched.
- rst_i asserted during beat 3 of a GrantData -> all entries free; the next Grant allocates index 0.
